// File: rtl/max_idx_10_pkg.sv
// Shared types and constants for the max_idx_10 argmax unit.
// Imported by the comparator leaf and the pipelined top.
package max_idx_10_pkg;

    localparam int NUM_VALUES = 10;
    localparam int IDX_W      = 4;
    localparam int DEF_WIDTH  = 8;

    typedef logic signed [DEF_WIDTH-1:0] val_arr_t [NUM_VALUES];

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/max_idx_10_sel2.sv
// Two-way (value, index) selector for the argmax tournament.
// Greater value wins; ties go to the lower index.
module max_sel2
    import max_idx_10_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_val,
    input  logic        [IDX_W-1:0] a_idx,
    input  logic signed [WIDTH-1:0] b_val,
    input  logic        [IDX_W-1:0] b_idx,
    output logic signed [WIDTH-1:0] y_val,
    output logic        [IDX_W-1:0] y_idx
);

    logic b_wins;

    // pick b only when strictly larger, or equal with a lower index
    always_comb begin
        b_wins = (b_val > a_val) ||
                 ((b_val == a_val) && (b_idx < a_idx));
        y_val  = b_wins ? b_val : a_val;
        y_idx  = b_wins ? b_idx : a_idx;
    end

endmodule

// File: rtl/max_idx_10.sv
// Pipelined argmax over ten signed values: 10 -> 5 -> 3 -> 2 -> 1.
// Result index and sticky done appear four clocks after the start edge.
module max_idx_10
    import max_idx_10_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] inputs [NUM_VALUES],
    input  logic                    start,
    output logic        [IDX_W-1:0] idx,
    output logic                    done
);

    state_t state;
    logic   [3:0] vld;
    logic   accept;

    logic signed [WIDTH-1:0] s0_val [NUM_VALUES];

    logic signed [WIDTH-1:0] c1_val [5];
    logic        [IDX_W-1:0] c1_idx [5];
    logic signed [WIDTH-1:0] s1_val [5];
    logic        [IDX_W-1:0] s1_idx [5];

    logic signed [WIDTH-1:0] c2_val [2];
    logic        [IDX_W-1:0] c2_idx [2];
    logic signed [WIDTH-1:0] s2_val [3];
    logic        [IDX_W-1:0] s2_idx [3];

    logic signed [WIDTH-1:0] c3_val;
    logic        [IDX_W-1:0] c3_idx;
    logic signed [WIDTH-1:0] s3_val [2];
    logic        [IDX_W-1:0] s3_idx [2];

    logic signed [WIDTH-1:0] fin_val_unused;
    logic        [IDX_W-1:0] fin_idx;

    assign accept = start && (state != BUSY);

    for (genvar g = 0; g < 5; g++) begin : g_l1
        max_sel2 #(.WIDTH(WIDTH)) u_sel (
            .a_val (s0_val[2*g]),
            .a_idx (IDX_W'(2*g)),
            .b_val (s0_val[2*g+1]),
            .b_idx (IDX_W'(2*g+1)),
            .y_val (c1_val[g]),
            .y_idx (c1_idx[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_l2
        max_sel2 #(.WIDTH(WIDTH)) u_sel (
            .a_val (s1_val[2*g]),
            .a_idx (s1_idx[2*g]),
            .b_val (s1_val[2*g+1]),
            .b_idx (s1_idx[2*g+1]),
            .y_val (c2_val[g]),
            .y_idx (c2_idx[g])
        );
    end

    max_sel2 #(.WIDTH(WIDTH)) u_l3 (
        .a_val (s2_val[0]),
        .a_idx (s2_idx[0]),
        .b_val (s2_val[1]),
        .b_idx (s2_idx[1]),
        .y_val (c3_val),
        .y_idx (c3_idx)
    );

    max_sel2 #(.WIDTH(WIDTH)) u_l4 (
        .a_val (s3_val[0]),
        .a_idx (s3_idx[0]),
        .b_val (s3_val[1]),
        .b_idx (s3_idx[1]),
        .y_val (fin_val_unused),
        .y_idx (fin_idx)
    );

    // tournament stage registers; sampling stage only loads on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VALUES; i++) s0_val[i] <= '0;
            for (int i = 0; i < 5; i++) begin
                s1_val[i] <= '0;
                s1_idx[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                s2_val[i] <= '0;
                s2_idx[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                s3_val[i] <= '0;
                s3_idx[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_VALUES; i++)
                    s0_val[i] <= inputs[i];
            end
            for (int i = 0; i < 5; i++) begin
                s1_val[i] <= c1_val[i];
                s1_idx[i] <= c1_idx[i];
            end
            s2_val[0] <= c2_val[0];
            s2_idx[0] <= c2_idx[0];
            s2_val[1] <= c2_val[1];
            s2_idx[1] <= c2_idx[1];
            s2_val[2] <= s1_val[4];
            s2_idx[2] <= s1_idx[4];
            s3_val[0] <= c3_val;
            s3_idx[0] <= c3_idx;
            s3_val[1] <= s2_val[2];
            s3_idx[1] <= s2_idx[2];
        end
    end

    // control FSM: valid token shift, busy/done state and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vld   <= '0;
            done  <= 1'b0;
            idx   <= '0;
        end else begin
            vld <= {vld[2:0], accept};
            unique case (state)
                IDLE: begin
                    if (start) state <= BUSY;
                end
                BUSY: begin
                    if (vld[3]) begin
                        state <= DONE;
                        done  <= 1'b1;
                        idx   <= fin_idx;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= BUSY;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_idx_10.sv
// Self-checking bench for max_idx_10 with a first-occurrence argmax model.
// Directed cases from the feature list followed by random trials.
module tb_max_idx_10;
    import max_idx_10_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    val_arr_t   din;
    logic [3:0] idx;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    max_idx_10 #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .inputs (din),
        .start  (start),
        .idx    (idx),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    function automatic int ref_argmax(input int v [10]);
        int best = 0;
        for (int i = 1; i < 10; i++)
            if (v[i] > v[best]) best = i;
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int v [10]);
        for (int i = 0; i < 10; i++) din[i] = 8'(v[i]);
    endtask

    task automatic fill(output int v [10], input int c);
        for (int i = 0; i < 10; i++) v[i] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_idx", {28'b0, idx}, 0);
    endtask

    task automatic run_check(input int v [10], input string tag);
        int e;
        e = ref_argmax(v);
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_d0"}, {31'b0, done}, 0);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s_d%0d", tag, c), {31'b0, done}, 0);
        end
        @(negedge clk);
        chk({tag, "_done"}, {31'b0, done}, 1);
        chk({tag, "_idx"}, {28'b0, idx}, e);
    endtask

    initial begin
        int v [10];
        int w [10];
        int e;
        int mode;

        reset = 1'b1;
        start = 1'b0;
        fill(v, 0);
        load(v);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_idx", {28'b0, idx}, 0);

        v = '{3, -5, 7, 100, -128, 0, 99, 1, 2, -1};
        run_check(v, "distinct");
        repeat (20) begin
            @(negedge clk);
            chk("sticky_done", {31'b0, done}, 1);
            chk("sticky_idx", {28'b0, idx}, 3);
        end

        fill(v, -128);
        v[6] = -127;
        run_check(v, "neg_only");

        do_reset();
        fill(v, 42);
        run_check(v, "all_tie");

        v = '{1, 2, 3, 4, 127, 5, 6, 7, 127, 8};
        run_check(v, "tie127");

        fill(v, 0);
        v[9] = 127;
        v[0] = -128;
        run_check(v, "extremes");

        v = '{10, 20, 50, -3, 0, 5, 7, 9, -50, 49};
        e = ref_argmax(v);
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din[7] = 8'sd120;
        repeat (3) @(negedge clk);
        chk("chg_early", {31'b0, done}, 0);
        @(negedge clk);
        chk("chg_done", {31'b0, done}, 1);
        chk("chg_idx", {28'b0, idx}, e);

        v = '{0, 90, 1, 2, 3, 4, 5, 6, 7, 8};
        w = '{0, 0, 0, 0, 0, 0, 0, 110, 0, 0};
        e = ref_argmax(v);
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(w);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_d2", {31'b0, done}, 0);
        @(negedge clk);
        chk("busy_d3", {31'b0, done}, 0);
        @(negedge clk);
        chk("busy_done", {31'b0, done}, 1);
        chk("busy_idx", {28'b0, idx}, e);
        repeat (8) begin
            @(negedge clk);
            chk("busy_hold_done", {31'b0, done}, 1);
            chk("busy_hold_idx", {28'b0, idx}, e);
        end

        v = '{1, 2, 3, 4, 5, 60, 7, 8, 9, 10};
        run_check(v, "after_done");

        v = '{1, 2, 3, 4, 5, 6, 7, 99, 9, 10};
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            chk("midrst_done", {31'b0, done}, 0);
            chk("midrst_idx", {28'b0, idx}, 0);
            @(negedge clk);
        end

        v = '{1, 2, 3, 4, 5, 60, 7, 8, 9, 10};
        run_check(v, "pre_rs");
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 77, 0};
        load(v);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (6) begin
            chk("rs_done", {31'b0, done}, 0);
            chk("rs_idx", {28'b0, idx}, 0);
            @(negedge clk);
        end

        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 10; i++) begin
                if (mode == 0)
                    v[i] = int'($urandom_range(0, 255)) - 128;
                else if (mode == 1)
                    v[i] = int'($urandom_range(0, 3)) - 2;
                else begin
                    case ($urandom_range(0, 3))
                        0: v[i] = -128;
                        1: v[i] = 127;
                        2: v[i] = 0;
                        default: v[i] = -1;
                    endcase
                end
            end
            run_check(v, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
